// File: rtl/alu_result_stage.sv
// EX->WB result register with a two-entry skid buffer and valid/ready handshake.
// Define ALU_STAGE_FLAGS_EN to build Zero/Negative/Overflow flag capture; otherwise flags read 0.
module alu_result_stage #(
    parameter int DATA_W = 24,
    parameter int RD_W   = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              InValid,
    output logic              InReady,
    input  logic [DATA_W-1:0] Result,
    input  logic [2:0]        Selector,
    input  logic              AddOvf,
    input  logic              RegWrite,
    input  logic [RD_W-1:0]   Rd,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] WBData,
    output logic [RD_W-1:0]   WBRd,
    output logic              WBWrite,
    output logic              Zero,
    output logic              Negative,
    output logic              Overflow
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state, next_state;

    logic              in_ready_q;
    logic              out_valid_q;
    logic              take_in;
    logic              take_out;
    logic              load_m;
    logic              load_s;
    logic              move_s;

    logic [DATA_W-1:0] m_data, s_data;
    logic [RD_W-1:0]   m_rd, s_rd;
    logic              m_wr, s_wr;

    assign take_in  = InValid && in_ready_q;
    assign take_out = out_valid_q && OutReady;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load_m     = 1'b0;
        load_s     = 1'b0;
        move_s     = 1'b0;
        case (state)
            EMPTY: begin
                if (take_in) begin
                    load_m     = 1'b1;
                    next_state = ONE;
                end
            end
            ONE: begin
                if (take_in && take_out) begin
                    load_m = 1'b1;
                end else if (take_in) begin
                    load_s     = 1'b1;
                    next_state = FULL;
                end else if (take_out) begin
                    next_state = EMPTY;
                end
            end
            FULL: begin
                // take_in cannot fire here: in_ready_q is low whenever S holds data
                if (take_out) begin
                    move_s     = 1'b1;
                    next_state = ONE;
                end
            end
            default: next_state = EMPTY;
        endcase
    end

    // Handshake outputs come straight from flops so OutReady never reaches InReady combinationally
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (next_state != FULL);
            out_valid_q <= (next_state != EMPTY);
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_data <= '0;
            m_rd   <= '0;
            m_wr   <= 1'b0;
        end else if (load_m) begin
            m_data <= Result;
            m_rd   <= Rd;
            m_wr   <= RegWrite;
        end else if (move_s) begin
            m_data <= s_data;
            m_rd   <= s_rd;
            m_wr   <= s_wr;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s_data <= '0;
            s_rd   <= '0;
            s_wr   <= 1'b0;
        end else if (load_s) begin
            s_data <= Result;
            s_rd   <= Rd;
            s_wr   <= RegWrite;
        end
    end

`ifdef ALU_STAGE_FLAGS_EN
    logic in_zero, in_neg, in_ovf;
    logic m_zero, m_neg, m_ovf;
    logic s_zero, s_neg, s_ovf;

    // Overflow only means something for ADD; every other select, including 1xx, clears it
    assign in_zero = (Result == '0);
    assign in_neg  = Result[DATA_W-1];
    assign in_ovf  = (Selector == 3'b010) && AddOvf;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            m_zero <= 1'b0;
            m_neg  <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (load_m) begin
            m_zero <= in_zero;
            m_neg  <= in_neg;
            m_ovf  <= in_ovf;
        end else if (move_s) begin
            m_zero <= s_zero;
            m_neg  <= s_neg;
            m_ovf  <= s_ovf;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            s_zero <= 1'b0;
            s_neg  <= 1'b0;
            s_ovf  <= 1'b0;
        end else if (load_s) begin
            s_zero <= in_zero;
            s_neg  <= in_neg;
            s_ovf  <= in_ovf;
        end
    end

    assign Zero     = m_zero;
    assign Negative = m_neg;
    assign Overflow = m_ovf;
`else
    logic unused_flag_inputs;
    assign unused_flag_inputs = ^{Selector, AddOvf};

    assign Zero     = 1'b0;
    assign Negative = 1'b0;
    assign Overflow = 1'b0;
`endif

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign WBData   = m_data;
    assign WBRd     = m_rd;
    assign WBWrite  = m_wr;

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomized + directed bench for alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [23:0] Result;
    logic [2:0]  Selector;
    logic        AddOvf;
    logic        RegWrite;
    logic [3:0]  Rd;
    logic        OutValid;
    logic        OutReady;
    logic [23:0] WBData;
    logic [3:0]  WBRd;
    logic        WBWrite;
    logic        Zero, Negative, Overflow;

    alu_result_stage #(.DATA_W(24), .RD_W(4)) dut (
        .Clock(Clock), .Reset(Reset), .InValid(InValid), .InReady(InReady),
        .Result(Result), .Selector(Selector), .AddOvf(AddOvf), .RegWrite(RegWrite),
        .Rd(Rd), .OutValid(OutValid), .OutReady(OutReady), .WBData(WBData),
        .WBRd(WBRd), .WBWrite(WBWrite), .Zero(Zero), .Negative(Negative),
        .Overflow(Overflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [23:0] data;
        logic [3:0]  rd;
        logic        wr;
        logic        z, n, o;
    } entry_t;

    entry_t q[$];
    int     n_chk  = 0;
    int     n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic entry_t mk(input logic [23:0] r, input logic [2:0] sel,
                                  input logic ao, input logic wr, input logic [3:0] rd);
        entry_t e;
        e.data = r;
        e.rd   = rd;
        e.wr   = wr;
`ifdef ALU_STAGE_FLAGS_EN
        e.z = (r == 24'd0);
        e.n = r[23];
        e.o = (sel == 3'b010) && ao;
`else
        e.z = 1'b0;
        e.n = 1'b0;
        e.o = 1'b0;
`endif
        return e;
    endfunction

    task automatic check_model();
        chk("out_valid", {31'd0, OutValid}, {31'd0, q.size() > 0});
        chk("in_ready", {31'd0, InReady}, {31'd0, q.size() < 2});
        if (q.size() > 0) begin
            chk("wb_data", {8'd0, WBData}, {8'd0, q[0].data});
            chk("wb_rd", {28'd0, WBRd}, {28'd0, q[0].rd});
            chk("wb_write", {31'd0, WBWrite}, {31'd0, q[0].wr});
            chk("flags", {29'd0, Zero, Negative, Overflow}, {29'd0, q[0].z, q[0].n, q[0].o});
        end
    endtask

    // Called at a negedge: drive, let one posedge happen, update model, check at next negedge
    task automatic step(input logic v, input logic [23:0] r, input logic [2:0] sel,
                        input logic ao, input logic wr, input logic [3:0] rd, input logic ordy);
        bit do_in, do_out;
        InValid  = v;
        Result   = r;
        Selector = sel;
        AddOvf   = ao;
        RegWrite = wr;
        Rd       = rd;
        OutReady = ordy;
        @(posedge Clock);
        do_in  = v && (q.size() < 2);
        do_out = ordy && (q.size() > 0);
        if (do_out) void'(q.pop_front());
        if (do_in) q.push_back(mk(r, sel, ao, wr, rd));
        @(negedge Clock);
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {31'd0, OutValid}, 32'd0);
        chk({tag, "_in_ready"}, {31'd0, InReady}, 32'd1);
        chk({tag, "_wb_data"}, {8'd0, WBData}, 32'd0);
        chk({tag, "_wb_rd"}, {28'd0, WBRd}, 32'd0);
        chk({tag, "_wb_write"}, {31'd0, WBWrite}, 32'd0);
        chk({tag, "_flags"}, {29'd0, Zero, Negative, Overflow}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; InValid = 1'b0; Result = '0; Selector = '0; AddOvf = 1'b0;
        RegWrite = 1'b0; Rd = '0; OutReady = 1'b0;
        #13;
        check_reset_outputs("reset");
        @(negedge Clock);
        Reset = 1'b0;

        // streaming at full throughput
        step(1, 24'h000001, 3'b010, 0, 1, 4'd1, 1);
        chk("stream1", {8'd0, WBData}, 32'h000001);
        step(1, 24'h000002, 3'b010, 0, 1, 4'd2, 1);
        chk("stream2", {8'd0, WBData}, 32'h000002);
        step(1, 24'h000003, 3'b010, 0, 1, 4'd3, 1);
        chk("stream3", {8'd0, WBData}, 32'h000003);
        chk("stream_valid", {31'd0, OutValid}, 32'd1);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);

        // back-pressure: second result lands in the skid register
        step(1, 24'hAAAAAA, 3'b001, 0, 1, 4'd5, 0);
        step(1, 24'h555555, 3'b001, 0, 0, 4'd6, 0);
        chk("bp_in_ready", {31'd0, InReady}, 32'd0);
        step(1, 24'h777777, 3'b001, 0, 1, 4'd7, 0);
        chk("bp_hold", {8'd0, WBData}, 32'hAAAAAA);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);
        chk("bp_second", {8'd0, WBData}, 32'h555555);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);
        chk("bp_drained", {31'd0, OutValid}, 32'd0);

        // flag capture
        step(1, 24'h000000, 3'b010, 1, 1, 4'd8, 0);
`ifdef ALU_STAGE_FLAGS_EN
        chk("flag_add_zero_ovf", {29'd0, Zero, Negative, Overflow}, 32'b101);
`else
        chk("noflag_add", {29'd0, Zero, Negative, Overflow}, 32'b000);
`endif
        chk("add_wb", {3'd0, WBWrite, WBRd, WBData}, {3'd0, 1'b1, 4'd8, 24'h000000});
        step(1, 24'h800000, 3'b001, 1, 0, 4'd9, 1);
`ifdef ALU_STAGE_FLAGS_EN
        chk("flag_or_neg", {29'd0, Zero, Negative, Overflow}, 32'b010);
`else
        chk("noflag_or", {29'd0, Zero, Negative, Overflow}, 32'b000);
`endif
        step(1, 24'h000000, 3'b110, 1, 1, 4'd10, 1);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);

        // simultaneous in/out while ONE
        step(1, 24'h123456, 3'b010, 0, 1, 4'd1, 0);
        step(1, 24'h654321, 3'b010, 0, 1, 4'd2, 1);
        chk("sim_data", {8'd0, WBData}, 32'h654321);
        chk("sim_in_ready", {31'd0, InReady}, 32'd1);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [23:0] r;
            r = ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom);
            step($urandom_range(0, 3) != 0, r, 3'($urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 9) < 7);
        end

        // reset mid-stream while FULL, checked without a clock edge
        step(1, 24'h111111, 3'b010, 1, 1, 4'd3, 0);
        step(1, 24'h222222, 3'b010, 1, 1, 4'd4, 0);
        step(1, 24'h333333, 3'b010, 1, 1, 4'd5, 0);
        chk("pre_reset_full", {31'd0, InReady}, 32'd0);
        #2 Reset = 1'b1;
        #1 check_reset_outputs("midreset");
        q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        step(1, 24'h0ABCDE, 3'b000, 0, 1, 4'd12, 1);
        chk("post_reset", {8'd0, WBData}, 32'h0ABCDE);
        step(0, 24'h0, 3'b000, 0, 0, 4'd0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
